vm_gen2: RTL and testbench
==========================

// Module: vm_gen2
// PURPOSE
//  Second-generation vending-machine controller. Holds NUM_ITEMS item slots with
//  per-slot stock count and cost, accepts coins, dispenses and returns change.
//  Refunds on cancel or watchdog timeout. Supplier restocks/re-prices via a valid-qualified port.
//  Sits between the coin/button front panel and the dispenser/change-hopper drivers.
// PARAMETERS
//  NUM_ITEMS   8    item slots; ITEM_W = $clog2(NUM_ITEMS)
//  CNT_W       4    stock-count width per slot
//  MAX_COUNT   15   slot capacity, must be <= 2**CNT_W-1
//  COST_W      8    item cost width, in cents
//  BAL_W       16   inserted-amount / balance width, in cents
//  TIMEOUT     512  idle cycles allowed in COLLECT before refund
// PORTS
//  clk        in   1       clock
//  hrst_n     in   1       asynchronous active-low hard reset
//  srst       in   1       synchronous soft reset (same effect as hrst_n, except stock/cost are kept)
//  coins      in   2       00 none, 01 nickel=5, 10 dime=10, 11 quarter=25
//  sel_valid  in   1       one-cycle item-selection strobe
//  sel_item   in   ITEM_W  selected slot
//  cancel     in   1       user cancel/refund request
//  valid      in   1       supplier restock qualifier
//  item       in   ITEM_W  restock slot
//  count      in   CNT_W   units added
//  cost       in   COST_W  new cost; 0 = keep current cost
//  product    out  ITEM_W  dispensed slot, meaningful when product_vld=1
//  product_vld out 1       one-cycle dispense pulse
//  status     out  2       00 IDLE, 01 AVAILABLE, 10 OUT_OF_STOCK, 11 ERROR
//  balance    out  BAL_W   change/refund amount, meaningful when change_vld=1
//  change_vld out  1       one-cycle change pulse
//  info       out  8       diagnostic, see CONFIGURATION
// BEHAVIOUR
//  Reset (hrst_n=0):
//   - all outputs 0, FSM=IDLE, amount=0, timer=TIMEOUT-1
//   - all stock counts 0, all costs 0
//  States: IDLE, CHECK, COLLECT, DISPENSE, CHANGE, RESTOCK; all outputs registered.
//  IDLE:
//   - valid -> RESTOCK, takes priority over sel_valid in the same cycle
//   - otherwise sel_valid -> CHECK, latches sel_item
//   - coins, and cancel received in IDLE, are ignored
//  CHECK (1 cycle):
//   - stock!=0 -> status=AVAILABLE, go to COLLECT
//   - stock==0 -> status=OUT_OF_STOCK, go to IDLE
//   - cost==0 counts as misconfigured -> status=ERROR, go to IDLE
//  COLLECT:
//   - each nonzero coins cycle adds its value to amount and reloads the timer
//   - a coin that would overflow BAL_W is dropped; status=ERROR, stay in COLLECT
//   - cycle after amount>=cost -> DISPENSE
//   - cancel, or timer reaching 0 -> CHANGE with balance=amount (refund), status=ERROR on timeout only
//   - cancel and a coin in the same cycle: the coin is counted, then refunded
//  DISPENSE (1 cycle):
//   - product=sel, product_vld=1, that slot's stock decremented
//   - go to CHANGE with balance=amount-cost, computed BAL_W wide with cost zero-extended
//  CHANGE (1 cycle):
//   - change_vld=1, even when balance=0
//   - amount cleared, status=IDLE, go to IDLE
//  RESTOCK, each valid cycle:
//   - stock+count > MAX_COUNT -> stock unchanged, status=ERROR
//   - else stock+=count, status=IDLE
//   - cost!=0 -> slot cost=cost
//   - valid=0 -> IDLE
//  Latency:
//   - sel_valid to status valid: 2 cycles
//   - paying coin to product_vld: 2 cycles
//   - product_vld to change_vld: 1 cycle
//  srst: returns to IDLE; mid-transaction amount is discarded without a change pulse.
//  hrst_n assertion mid-operation aborts at once, with no dispense and no change pulse.
// CONFIGURATION
//  VM_SALES_LOG_EN defined:
//   - per-slot 8-bit sales counters, saturating at 255, increment on product_vld
//   - info = sales counter of the last selected slot
//   - counters cleared by hrst_n only
//  VM_SALES_LOG_EN undefined: info = {0, stock count of last selected slot}, no counters built.
// STRUCTURE
//  Package vm_gen2_pkg: status_e, coin_e, state_e, coin-value constants, coin_value() function.
//  Sub-module vm_wdt: TIMEOUT down-counter with ports clk, hrst_n, load, en, expired.
// TESTING
//  1. Restock item=2,count=5,cost=35, then select 2, coins Q,D -> product_vld slot 2, balance=0, stock 4.
//  2. Select slot with stock 0 -> status=OUT_OF_STOCK 2 cycles after sel_valid, back to IDLE.
//  3. cost=30, insert Q,Q -> dispense, balance=20, change_vld 1 cycle after product_vld.
//  4. Insert D, no further coins for 512 cycles -> change_vld, balance=10, status=ERROR.
//  5. Stock 12, restock count=5 -> status=ERROR, stock stays 12; valid+sel_valid same cycle -> RESTOCK.
//  6. Assert hrst_n=0 during COLLECT with amount=25 -> outputs 0, no change pulse; info per macro.

Source files
------------

// File: rtl/vm_gen2_pkg.sv
// Shared types and coin helpers for the vm_gen2 vending-machine controller.
package vm_gen2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_AVAILABLE    = 2'b01,
    ST_OUT_OF_STOCK = 2'b10,
    ST_ERROR        = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE,
    S_RESTOCK
  } state_e;

  localparam logic [4:0] NICKEL_CENTS  = 5'd5;
  localparam logic [4:0] DIME_CENTS    = 5'd10;
  localparam logic [4:0] QUARTER_CENTS = 5'd25;

  function automatic logic [4:0] coin_value(input coin_e c);
    logic [4:0] v;
    v = '0;
    unique case (c)
      COIN_NICKEL:  v = NICKEL_CENTS;
      COIN_DIME:    v = DIME_CENTS;
      COIN_QUARTER: v = QUARTER_CENTS;
      default:      v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm_wdt.sv
// Collect-phase watchdog: down-counter reloaded to TIMEOUT-1, expired at terminal count 0.
module vm_wdt #(
  parameter int TIMEOUT = 512
) (
  input  logic clk,
  input  logic hrst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      cnt_q <= RELOAD;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/vm_gen2.sv
// Vending-machine controller: stock/cost slots, coin collection, dispense, change and refund.
// Optional per-slot sales log enabled by defining VM_SALES_LOG_EN.
//   state    | meaning
//   IDLE     | waiting for a selection or a restock
//   CHECK    | judge stock and cost of the latched slot
//   COLLECT  | accumulate coins, watchdog running
//   DISPENSE | product pulse, stock decrement, compute change
//   CHANGE   | change pulse, clear amount
//   RESTOCK  | apply supplier updates while valid stays high
module vm_gen2 import vm_gen2_pkg::*; #(
  parameter int NUM_ITEMS = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 15,
  parameter int COST_W    = 8,
  parameter int BAL_W     = 16,
  parameter int TIMEOUT   = 512,
  localparam int ITEM_W   = $clog2(NUM_ITEMS)
) (
  input  logic              clk,
  input  logic              hrst_n,
  input  logic              srst,
  input  logic [1:0]        coins,
  input  logic              sel_valid,
  input  logic [ITEM_W-1:0] sel_item,
  input  logic              cancel,
  input  logic              valid,
  input  logic [ITEM_W-1:0] item,
  input  logic [CNT_W-1:0]  count,
  input  logic [COST_W-1:0] cost,
  output logic [ITEM_W-1:0] product,
  output logic              product_vld,
  output logic [1:0]        status,
  output logic [BAL_W-1:0]  balance,
  output logic              change_vld,
  output logic [7:0]        info
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_COUNT);

  state_e                           state_q, state_d;
  logic [ITEM_W-1:0]                sel_q, sel_d;
  logic [BAL_W-1:0]                 amount_q, amount_d;
  logic [NUM_ITEMS-1:0][CNT_W-1:0]  stock_q, stock_d;
  logic [NUM_ITEMS-1:0][COST_W-1:0] cost_q, cost_d;
  logic [ITEM_W-1:0]                product_q, product_d;
  logic                             product_vld_q, product_vld_d;
  status_e                          status_q, status_d;
  logic [BAL_W-1:0]                 balance_q, balance_d;
  logic                             change_vld_q, change_vld_d;
  logic [7:0]                       info_q, info_d;

  coin_e            coin_in;
  logic [4:0]       coin_cents;
  logic [BAL_W:0]   coin_sum;
  logic [BAL_W-1:0] sel_cost;
  logic [CNT_W:0]   restock_sum;
  logic [7:0]       info_src;
  logic             restock_apply;
  logic             wdt_load, wdt_en, wdt_expired;

  assign coin_in     = coin_e'(coins);
  assign coin_cents  = coin_value(coin_in);
  assign coin_sum    = {1'b0, amount_q} + {{(BAL_W-4){1'b0}}, coin_cents};
  assign sel_cost    = {{(BAL_W-COST_W){1'b0}}, cost_q[sel_q]};
  assign restock_sum = {1'b0, stock_q[item]} + {1'b0, count};

  vm_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk     (clk),
    .hrst_n  (hrst_n),
    .load    (wdt_load),
    .en      (wdt_en),
    .expired (wdt_expired)
  );

`ifdef VM_SALES_LOG_EN
  logic [NUM_ITEMS-1:0][7:0] sales_q;

  // Counters survive srst; only the hard reset clears them.
  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      sales_q <= '0;
    end else if (product_vld_q && (sales_q[product_q] != 8'hFF)) begin
      sales_q[product_q] <= sales_q[product_q] + 8'd1;
    end
  end

  assign info_src = sales_q[sel_q];
`else
  assign info_src = {{(8-CNT_W){1'b0}}, stock_q[sel_q]};
`endif

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    amount_d      = amount_q;
    stock_d       = stock_q;
    cost_d        = cost_q;
    product_d     = product_q;
    product_vld_d = 1'b0;
    status_d      = status_q;
    balance_d     = balance_q;
    change_vld_d  = 1'b0;
    info_d        = info_src;
    restock_apply = 1'b0;
    wdt_load      = 1'b1;
    wdt_en        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          restock_apply = 1'b1;
          state_d       = S_RESTOCK;
        end else if (sel_valid) begin
          sel_d   = sel_item;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (stock_q[sel_q] == '0) begin
          status_d = ST_OUT_OF_STOCK;
          state_d  = S_IDLE;
        end else if (cost_q[sel_q] == '0) begin
          status_d = ST_ERROR;
          state_d  = S_IDLE;
        end else begin
          status_d = ST_AVAILABLE;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        wdt_load = 1'b0;
        wdt_en   = 1'b1;
        if (amount_q >= sel_cost) begin
          product_d     = sel_q;
          product_vld_d = 1'b1;
          state_d       = S_DISPENSE;
        end else begin
          if (coin_in != COIN_NONE) begin
            wdt_load = 1'b1;
            if (coin_sum[BAL_W]) status_d = ST_ERROR;
            else                 amount_d = coin_sum[BAL_W-1:0];
          end
          // A coin arriving with cancel is banked first so it is refunded too.
          if (cancel) begin
            balance_d    = amount_d;
            change_vld_d = 1'b1;
            state_d      = S_CHANGE;
          end else if ((coin_in == COIN_NONE) && wdt_expired) begin
            balance_d    = amount_q;
            change_vld_d = 1'b1;
            status_d     = ST_ERROR;
            state_d      = S_CHANGE;
          end
        end
      end
      S_DISPENSE: begin
        stock_d[sel_q] = stock_q[sel_q] - CNT_W'(1);
        balance_d      = amount_q - sel_cost;
        change_vld_d   = 1'b1;
        state_d        = S_CHANGE;
      end
      S_CHANGE: begin
        amount_d = '0;
        status_d = ST_IDLE;
        state_d  = S_IDLE;
      end
      S_RESTOCK: begin
        if (valid) restock_apply = 1'b1;
        else       state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (restock_apply) begin
      if (restock_sum > MAX_CNT) begin
        status_d = ST_ERROR;
      end else begin
        stock_d[item] = restock_sum[CNT_W-1:0];
        status_d      = ST_IDLE;
      end
      if (cost != '0) cost_d[item] = cost;
    end

    // Soft reset behaves like the hard reset but keeps the slot table.
    if (srst) begin
      state_d       = S_IDLE;
      sel_d         = '0;
      amount_d      = '0;
      stock_d       = stock_q;
      cost_d        = cost_q;
      product_d     = '0;
      product_vld_d = 1'b0;
      status_d      = ST_IDLE;
      balance_d     = '0;
      change_vld_d  = 1'b0;
      info_d        = '0;
      wdt_load      = 1'b1;
      wdt_en        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      amount_q      <= '0;
      stock_q       <= '0;
      cost_q        <= '0;
      product_q     <= '0;
      product_vld_q <= 1'b0;
      status_q      <= ST_IDLE;
      balance_q     <= '0;
      change_vld_q  <= 1'b0;
      info_q        <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      amount_q      <= amount_d;
      stock_q       <= stock_d;
      cost_q        <= cost_d;
      product_q     <= product_d;
      product_vld_q <= product_vld_d;
      status_q      <= status_d;
      balance_q     <= balance_d;
      change_vld_q  <= change_vld_d;
      info_q        <= info_d;
    end
  end

  assign product     = product_q;
  assign product_vld = product_vld_q;
  assign status      = status_q;
  assign balance     = balance_q;
  assign change_vld  = change_vld_q;
  assign info        = info_q;

endmodule

// File: tb/tb_vm_gen2.sv
// Scoreboard bench for vm_gen2: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_vm_gen2;

  localparam int NI = 8;
  localparam int TO = 512;
  localparam logic [1:0] E_IDLE = 2'd0, E_AVAIL = 2'd1, E_OOS = 2'd2, E_ERR = 2'd3;

  logic        clk = 1'b0, hrst_n = 1'b0, srst = 1'b0;
  logic [1:0]  coins = 2'b00;
  logic        sel_valid = 1'b0, cancel = 1'b0, valid = 1'b0;
  logic [2:0]  sel_item = '0, item = '0;
  logic [3:0]  count = '0;
  logic [7:0]  cost = '0;
  logic [2:0]  product;
  logic        product_vld, change_vld;
  logic [1:0]  status;
  logic [15:0] balance;
  logic [7:0]  info;

  vm_gen2 dut (
    .clk(clk), .hrst_n(hrst_n), .srst(srst), .coins(coins),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .valid(valid), .item(item), .count(count), .cost(cost),
    .product(product), .product_vld(product_vld), .status(status),
    .balance(balance), .change_vld(change_vld), .info(info)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_change;
    int unsigned val;
    bit          chk_st;
    logic [1:0]  st;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  int m_stock[NI];
  int m_cost[NI];
  int m_sales[NI];
  int m_amount = 0;
  int m_sel = 0;
  bit m_paid = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int cval(input int c);
    case (c)
      1: return 5;
      2: return 10;
      3: return 25;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (hrst_n && (product_vld || change_vld)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {product_vld, change_vld}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {product_vld, change_vld}, e.is_change ? 2'b01 : 2'b10);
        check("pulse_cycle", cyc, e.due);
        if (!e.is_change) check("product", product, e.val);
        else begin
          check("balance", balance, e.val);
          if (e.chk_st) check("change_status", status, e.st);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic restock(input int it, input int cnt, input int cst);
    logic [1:0] st;
    valid = 1'b1; item = it[2:0]; count = cnt[3:0]; cost = cst[7:0];
    tick();
    valid = 1'b0;
    if (m_stock[it] + cnt > 15) st = E_ERR;
    else begin
      m_stock[it] += cnt;
      st = E_IDLE;
    end
    if (cst != 0) m_cost[it] = cst;
    check("restock_status", status, st);
    tick();
  endtask

  task automatic select(input int it, output bit ok);
    logic [1:0] st;
    sel_valid = 1'b1; sel_item = it[2:0];
    tick();
    sel_valid = 1'b0;
    tick();
    if (m_stock[it] == 0)     st = E_OOS;
    else if (m_cost[it] == 0) st = E_ERR;
    else                      st = E_AVAIL;
    check("select_status", status, st);
`ifdef VM_SALES_LOG_EN
    check("info", info, m_sales[it]);
`else
    check("info", info, m_stock[it]);
`endif
    ok = (st == E_AVAIL);
    m_sel = it;
    m_amount = 0;
    m_paid = 0;
  endtask

  task automatic coin(input int c);
    int k;
    k = cyc;
    coins = c[1:0];
    tick();
    coins = 2'b00;
    m_amount += cval(c);
    if (m_amount >= m_cost[m_sel]) begin
      exp_q.push_back('{1'b0, m_sel, 1'b0, 2'b00, k + 2});
      exp_q.push_back('{1'b1, m_amount - m_cost[m_sel], 1'b0, 2'b00, k + 3});
      m_stock[m_sel]--;
      if (m_sales[m_sel] < 255) m_sales[m_sel]++;
      m_amount = 0;
      m_paid = 1;
      tick(); tick(); tick();
      drain(10);
    end
  endtask

  task automatic do_cancel(input int c);
    int k;
    k = cyc;
    coins = c[1:0]; cancel = 1'b1;
    tick();
    coins = 2'b00; cancel = 1'b0;
    m_amount += cval(c);
    exp_q.push_back('{1'b1, m_amount, 1'b0, 2'b00, k + 1});
    m_amount = 0;
    tick();
    drain(10);
  endtask

  task automatic coin_timeout(input int c);
    int k;
    k = cyc;
    coins = c[1:0];
    tick();
    coins = 2'b00;
    m_amount += cval(c);
    exp_q.push_back('{1'b1, m_amount, 1'b1, E_ERR, k + 1 + TO});
    drain(TO + 40);
    tick();
    m_amount = 0;
  endtask

  initial begin
    bit ok;
    int it;
    for (int i = 0; i < NI; i++) begin
      m_stock[i] = 0; m_cost[i] = 0; m_sales[i] = 0;
    end
    tick(); tick();
    check("rst_product_vld", product_vld, 0);
    check("rst_change_vld", change_vld, 0);
    check("rst_status", status, E_IDLE);
    check("rst_balance", balance, 0);
    check("rst_info", info, 0);
    hrst_n = 1'b1;
    tick();

    // Restock, buy with exact change, then confirm stock went to 4.
    restock(2, 5, 35);
    select(2, ok);
    coin(3);
    coin(2);
    check("t1_paid", m_paid, 1);
    select(2, ok);
    do_cancel(0);

    // Empty slot.
    select(5, ok);
    tick();
    check("oos_back_idle_status", status, E_OOS);

    // Change of 20.
    restock(3, 2, 30);
    select(3, ok);
    coin(3);
    coin(3);

    // Watchdog refund.
    select(3, ok);
    coin_timeout(2);

    // Restock overflow, and restock winning over a same-cycle selection.
    restock(6, 12, 20);
    restock(6, 5, 0);
    select(6, ok);
    do_cancel(1);
    valid = 1'b1; item = 3'd6; count = 4'd1; cost = 8'd0;
    sel_valid = 1'b1; sel_item = 3'd6;
    tick();
    valid = 1'b0; sel_valid = 1'b0;
    m_stock[6] += 1;
    check("restock_priority_status", status, E_IDLE);
    tick(); tick();
    check("sel_ignored_status", status, E_IDLE);
    select(6, ok);
    do_cancel(0);

    // Soft reset mid-collect: amount dropped, no pulse, slot table kept.
    restock(4, 2, 50);
    select(4, ok);
    coin(3);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    m_amount = 0;
    check("srst_status", status, E_IDLE);
    check("srst_balance", balance, 0);
    tick(); tick(); tick();
    select(4, ok);
    coin(3);
    coin(3);
    check("srst_paid", m_paid, 1);

    // Hard reset mid-collect with 25 cents banked.
    restock(1, 3, 35);
    select(1, ok);
    coin(3);
    hrst_n = 1'b0;
    #1;
    check("hrst_product_vld", product_vld, 0);
    check("hrst_change_vld", change_vld, 0);
    check("hrst_status", status, 0);
    check("hrst_balance", balance, 0);
    check("hrst_info", info, 0);
    tick(); tick();
    hrst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      m_stock[i] = 0; m_cost[i] = 0; m_sales[i] = 0;
    end
    m_amount = 0;
    tick(); tick();
    select(1, ok);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 0)
        restock($urandom_range(0, 7), $urandom_range(0, 6),
                ($urandom_range(0, 5) == 0) ? 0 : 5 * $urandom_range(1, 12));
      it = $urandom_range(0, 7);
      select(it, ok);
      if (ok) begin
        for (int n = 0; n < 20 && !m_paid; n++) begin
          if ($urandom_range(0, 7) == 0) begin
            do_cancel($urandom_range(0, 3));
            break;
          end
          coin($urandom_range(1, 3));
        end
        if (!m_paid && m_amount != 0) do_cancel(0);
      end
      tick();
    end

    drain(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
